riscv_load_store_unit: RTL and testbench
========================================

# riscv_load_store_unit

Memory-access stage of the RV32I pipeline, sitting directly downstream of the ID/EX → EX pipeline register and the ALU. It takes one executed instruction at a time, performs the data-memory access for loads and stores over a simple request/acknowledge bus, and produces a write-back result. It handles byte-lane steering, load sign/zero extension, misalignment and illegal-width detection, and a bus timeout. It stalls the upstream pipeline while an access is outstanding.

## Interface
Parameters:
- `XLEN`: global define from riscv_configs.v, value 32. Datapath width.
- TIMEOUT_CYCLES: default 255. Maximum number of BUSY cycles without acknowledge before the access is aborted. Legal range 1..1023.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  unit can accept this cycle; also the inverted upstream stall.
- i_flush  in  1  kill the instruction presented this cycle.
- i_mem_read  in  1  instruction is a load.
- i_mem_write  in  1  instruction is a store.
- i_funct3  in  3  access width and sign.
- i_addr  in  `XLEN  ALU result: effective address, or the result value for non-memory instructions.
- i_wdata  in  `XLEN  store data (rs2).
- i_rd  in  5  destination register.
- i_rd_we  in  1  destination write enable for non-memory instructions.
- o_dmem_req  out  1  bus request.
- o_dmem_we  out  1  bus write.
- o_dmem_addr  out  `XLEN  word-aligned address; bits [1:0] are 0.
- o_dmem_be  out  4  byte enables.
- o_dmem_wdata  out  `XLEN  lane-steered store data.
- i_dmem_ack  in  1  bus acknowledge; i_dmem_rdata is valid in the same cycle.
- i_dmem_rdata  in  `XLEN  read word.
- o_valid  out  1  one-cycle result pulse.
- o_result  out  `XLEN  write-back data.
- o_rd  out  5  destination register.
- o_rd_we  out  1  register-file write enable.
- o_misaligned  out  1  exception flag.
- o_illegal  out  1  exception flag.
- o_bus_err  out  1  exception flag.

## Operation
- FSM states are IDLE and BUSY. o_ready is 1 only in IDLE.
- Accept condition in IDLE: i_valid & !i_flush. If i_flush is set, the instruction is dropped.
- Non-memory instruction: on the next cycle, o_valid=1, o_result=i_addr, o_rd=i_rd, o_rd_we=i_rd_we. The FSM stays in IDLE.
- Memory instruction, illegal width:
  - Loads with funct3 011, 110 or 111, and stores with funct3 above 010, are illegal.
  - Response: o_valid=1 next cycle with o_illegal=1 and o_rd_we=0. No bus access. The illegal check takes priority over the misalignment check.
- Memory instruction, misaligned:
  - Halfword access with addr[0]=1, or word access with addr[1:0]≠0.
  - Response: o_valid=1 next cycle with o_misaligned=1 and o_rd_we=0. No bus access.
- Memory instruction, otherwise:
  - Transition to BUSY. The bus outputs are registered at acceptance.
  - Store byte enables: SB gives be=1<<addr[1:0]; SH gives 0011 or 1100; SW gives 1111.
  - Store data is replicated across lanes: byte ×4, half ×2.
- BUSY:
  - o_dmem_req=1. All bus outputs are held stable until i_dmem_ack.
  - On ack: the load result is extracted from byte lane addr[1:0] and extended. LB and LH sign-extend; LBU and LHU zero-extend. o_rd_we=1 for loads, 0 for stores. o_valid is raised the next cycle, and the FSM returns to IDLE.
- Timeout:
  - A counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES, the request is dropped and o_valid=1 with o_bus_err=1 and o_rd_we=0. The FSM returns to IDLE.
  - An ack arriving in that same cycle wins over the timeout.
- i_flush during BUSY is ignored; the access completes.
- i_dmem_ack while in IDLE is ignored.
- The exception flags are valid only while o_valid=1.

## Timing
- Reset: state=IDLE, counter=0. Every output is 0 except o_ready=1.
- Reset in BUSY: o_dmem_req is 0 after the reset edge, and any later ack is ignored.
- Non-memory instructions and exceptions: accepted at cycle N, o_valid at N+1. Back-to-back accepts sustain one instruction per cycle.
- Memory access: accepted at N. o_dmem_req is high from N+1. Ack arrives at N+1+k (k≥0). o_valid is at N+2+k, and o_ready is 1 again at N+2+k.
- o_valid is a single-cycle pulse. Downstream never back-pressures.
- Timeout: o_bus_err pulse at N+2+TIMEOUT_CYCLES when no ack arrives.

## Structure
- riscv_configs.v holds the funct3 width defines (`FUNCT3_B`, `FUNCT3_H`, `FUNCT3_W`, `FUNCT3_BU`, `FUNCT3_HU`).
- The FSM state encodings are local parameters.
- Sub-module riscv_load_align: combinational lane select plus sign/zero extension. It is reused by later cache work.
- Counter width is $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Non-memory instruction: i_addr=0x1234 with rd=5 and rd_we=1 → the next cycle gives o_valid=1, o_result=0x1234, o_rd=5, o_rd_we=1, with o_ready held at 1.
- SB to address 0x103 with wdata=0xAB → dmem_addr=0x100, be=1000, wdata=0xABABABAB. With ack after 2 wait cycles, o_valid arrives 4 cycles after accept and o_rd_we=0.
- LB from 0x102, rdata=0x0080_0000 → o_result=0xFFFFFF80. The same access as LBU → 0x00000080.
- LW from 0x102 → o_misaligned=1 the next cycle and o_dmem_req never rises. LW with funct3=011 → o_illegal=1.
- No ack with TIMEOUT_CYCLES=4 → o_bus_err pulse 6 cycles after accept. An ack driven in the 4th BUSY cycle instead completes the access normally.
- i_rst asserted during BUSY, then an ack → req=0 after the reset edge, no o_valid, o_ready=1. i_flush with i_valid in IDLE → no output.

Source files
------------

// File: rtl/riscv_load_store_unit_pkg.sv
// rtl/riscv_load_store_unit_pkg.sv - access decode and store lane-steering helpers
`include "riscv_configs.v"

package riscv_load_store_unit_pkg;

    function automatic logic width_illegal(input logic is_load, input logic [2:0] funct3);
        if (is_load)
            return (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        else
            return funct3 > `FUNCT3_W;
    endfunction

    // Only the size bits matter here; signedness has no bearing on alignment.
    function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   return 4'b0001 << addr_lo;
            2'b01:   return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [`XLEN-1:0] store_data(input logic [1:0] size, input logic [`XLEN-1:0] wdata);
        case (size)
            2'b00:   return {(`XLEN/8){wdata[7:0]}};
            2'b01:   return {(`XLEN/16){wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/riscv_configs.v
// rtl/riscv_configs.v - global RV32I datapath width and funct3 access-width codes
`ifndef RISCV_CONFIGS_V
`define RISCV_CONFIGS_V
`define XLEN      32
`define FUNCT3_B  3'b000
`define FUNCT3_H  3'b001
`define FUNCT3_W  3'b010
`define FUNCT3_BU 3'b100
`define FUNCT3_HU 3'b101
`endif

// File: rtl/riscv_load_align.sv
// rtl/riscv_load_align.sv - load byte-lane select with sign/zero extension
`include "riscv_configs.v"

module riscv_load_align
    import riscv_load_store_unit_pkg::*;
(
    input  logic [`XLEN-1:0] rdata,
    input  logic [1:0]       offset,
    input  logic [2:0]       funct3,
    output logic [`XLEN-1:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            `FUNCT3_B:  result = {{(`XLEN-8){lane_b[7]}}, lane_b};
            `FUNCT3_BU: result = {{(`XLEN-8){1'b0}}, lane_b};
            `FUNCT3_H:  result = {{(`XLEN-16){lane_h[15]}}, lane_h};
            `FUNCT3_HU: result = {{(`XLEN-16){1'b0}}, lane_h};
            default:    result = rdata;
        endcase
    end

endmodule

// File: rtl/riscv_load_store_unit.sv
// rtl/riscv_load_store_unit.sv - RV32I memory stage: bus access, alignment, timeout
`include "riscv_configs.v"

module riscv_load_store_unit
    import riscv_load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_flush,
    input  logic             i_mem_read,
    input  logic             i_mem_write,
    input  logic [2:0]       i_funct3,
    input  logic [`XLEN-1:0] i_addr,
    input  logic [`XLEN-1:0] i_wdata,
    input  logic [4:0]       i_rd,
    input  logic             i_rd_we,
    output logic             o_dmem_req,
    output logic             o_dmem_we,
    output logic [`XLEN-1:0] o_dmem_addr,
    output logic [3:0]       o_dmem_be,
    output logic [`XLEN-1:0] o_dmem_wdata,
    input  logic             i_dmem_ack,
    input  logic [`XLEN-1:0] i_dmem_rdata,
    output logic             o_valid,
    output logic [`XLEN-1:0] o_result,
    output logic [4:0]       o_rd,
    output logic             o_rd_we,
    output logic             o_misaligned,
    output logic             o_illegal,
    output logic             o_bus_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [2:0]      ld_funct3;
    logic [1:0]      ld_offset;
    logic [4:0]      ld_rd;
    logic            ld_is_load;
    logic [`XLEN-1:0] ld_result;

    logic is_mem, accept, illegal, misaligned, start_bus, timeout, done;

    assign is_mem     = i_mem_read | i_mem_write;
    assign accept     = o_ready & i_valid & ~i_flush;
    assign illegal    = width_illegal(i_mem_read, i_funct3);
    assign misaligned = addr_misaligned(i_funct3[1:0], i_addr[1:0]);
    assign start_bus  = accept & is_mem & ~illegal & ~misaligned;
    // A late ack in the final allowed cycle still completes the access.
    assign timeout    = (state == BUSY) & ~i_dmem_ack & (cnt == CW'(TIMEOUT_CYCLES));
    assign done       = (state == BUSY) & (i_dmem_ack | timeout);
    assign o_ready    = (state == IDLE);

    riscv_load_align u_align (
        .rdata  (i_dmem_rdata),
        .offset (ld_offset),
        .funct3 (ld_funct3),
        .result (ld_result)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_bus) state_next = BUSY;
            BUSY:    if (done)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt          <= '0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_be    <= 4'b0000;
            o_dmem_wdata <= '0;
            ld_funct3    <= 3'b000;
            ld_offset    <= 2'b00;
            ld_rd        <= 5'd0;
            ld_is_load   <= 1'b0;
        end else if (start_bus) begin
            cnt          <= '0;
            o_dmem_req   <= 1'b1;
            o_dmem_we    <= ~i_mem_read;
            o_dmem_addr  <= {i_addr[`XLEN-1:2], 2'b00};
            o_dmem_be    <= store_be(i_funct3[1:0], i_addr[1:0]);
            o_dmem_wdata <= store_data(i_funct3[1:0], i_wdata);
            ld_funct3    <= i_funct3;
            ld_offset    <= i_addr[1:0];
            ld_rd        <= i_rd;
            ld_is_load   <= i_mem_read;
        end else if (done) begin
            o_dmem_req   <= 1'b0;
        end else if (state == BUSY) begin
            cnt          <= cnt + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid      <= 1'b0;
            o_result     <= '0;
            o_rd         <= 5'd0;
            o_rd_we      <= 1'b0;
            o_misaligned <= 1'b0;
            o_illegal    <= 1'b0;
            o_bus_err    <= 1'b0;
        end else begin
            o_valid      <= 1'b0;
            o_rd_we      <= 1'b0;
            o_misaligned <= 1'b0;
            o_illegal    <= 1'b0;
            o_bus_err    <= 1'b0;
            if (accept && !start_bus) begin
                o_valid <= 1'b1;
                o_rd    <= i_rd;
                if (!is_mem) begin
                    o_result <= i_addr;
                    o_rd_we  <= i_rd_we;
                end else begin
                    o_result     <= '0;
                    o_illegal    <= illegal;
                    o_misaligned <= ~illegal & misaligned;
                end
            end else if (done) begin
                o_valid   <= 1'b1;
                o_rd      <= ld_rd;
                o_result  <= (i_dmem_ack && ld_is_load) ? ld_result : '0;
                o_rd_we   <= i_dmem_ack & ld_is_load;
                o_bus_err <= timeout;
            end
        end
    end

endmodule

// File: tb/tb_riscv_load_store_unit.sv
// tb/tb_riscv_load_store_unit.sv - directed self-checking bench for the load/store unit
`timescale 1ns/1ps

module tb_riscv_load_store_unit;

    logic        clk = 1'b0;
    logic        rst, valid, ready, flush, mem_read, mem_write, rd_we_in;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, dmem_addr, dmem_wdata, dmem_rdata, result;
    logic [4:0]  rd_in, rd;
    logic        dmem_req, dmem_we, dmem_ack, res_valid, rd_we, misaligned, illegal, bus_err;
    logic [3:0]  dmem_be;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    riscv_load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready), .i_flush(flush),
        .i_mem_read(mem_read), .i_mem_write(mem_write), .i_funct3(funct3),
        .i_addr(addr), .i_wdata(wdata), .i_rd(rd_in), .i_rd_we(rd_we_in),
        .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
        .o_dmem_be(dmem_be), .o_dmem_wdata(dmem_wdata), .i_dmem_ack(dmem_ack),
        .i_dmem_rdata(dmem_rdata), .o_valid(res_valid), .o_result(result), .o_rd(rd),
        .o_rd_we(rd_we), .o_misaligned(misaligned), .o_illegal(illegal), .o_bus_err(bus_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                         input logic we);
        valid = 1'b1; mem_read = rd_op; mem_write = wr_op; funct3 = f3;
        addr = a; wdata = wd; rd_in = r; rd_we_in = we;
    endtask

    task automatic release_inputs();
        valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0; flush = 1'b0;
        release_inputs();
        funct3 = '0; addr = '0; wdata = '0; rd_in = '0; rd_we_in = 1'b0;
        step(); step();
        n_checks++;
        if ({ready, dmem_req, dmem_we, dmem_be, res_valid, rd_we, misaligned, illegal, bus_err} !== 12'b1_0_0_0000_0_0_0_0_0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 100000000000",
                {ready, dmem_req, dmem_we, dmem_be, res_valid, rd_we, misaligned, illegal, bus_err});
        end
        n_checks++;
        if ({dmem_addr, dmem_wdata, result, rd} !== {32'h0, 32'h0, 32'h0, 5'd0}) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h want zeros", dmem_addr, dmem_wdata, result, rd);
        end
        rst = 1'b0;
    endtask

    task automatic test_non_mem();
        drive(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1);
        step();
        release_inputs();
        n_checks++;
        if ({res_valid, result, rd, rd_we, ready, dmem_req} !== {1'b1, 32'h1234, 5'd5, 1'b1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL non_mem: got v=%b res=%h rd=%0d we=%b rdy=%b req=%b want 1 1234 5 1 1 0",
                res_valid, result, rd, rd_we, ready, dmem_req);
        end
        step();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++; $display("FAIL non_mem_pulse: got %b want 0", res_valid);
        end
    endtask

    task automatic test_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd, input int waits);
        drive(1'b0, 1'b1, f3, a, wd, 5'd7, 1'b0);
        step();
        release_inputs();
        n_checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ready} !== {1'b1, 1'b1, {a[31:2], 2'b00}, exp_be, exp_wd, 1'b0}) begin
            n_fail++; $display("FAIL store_bus f3=%0d: got req=%b we=%b a=%h be=%b wd=%h rdy=%b want 1 1 %h %b %h 0",
                f3, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ready, {a[31:2], 2'b00}, exp_be, exp_wd);
        end
        for (int i = 0; i < waits; i++) step();
        n_checks++;
        if ({dmem_req, dmem_addr, dmem_be, dmem_wdata, res_valid} !== {1'b1, {a[31:2], 2'b00}, exp_be, exp_wd, 1'b0}) begin
            n_fail++; $display("FAIL store_hold: got req=%b a=%h be=%b wd=%h v=%b", dmem_req, dmem_addr, dmem_be, dmem_wdata, res_valid);
        end
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        n_checks++;
        if ({res_valid, rd_we, ready, dmem_req, bus_err} !== 5'b10100) begin
            n_fail++; $display("FAIL store_done: got v=%b we=%b rdy=%b req=%b err=%b want 1 0 1 0 0",
                res_valid, rd_we, ready, dmem_req, bus_err);
        end
    endtask

    task automatic test_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdw,
                             input logic [31:0] exp);
        drive(1'b1, 1'b0, f3, a, 32'h0, 5'd9, 1'b0);
        step();
        release_inputs();
        n_checks++;
        if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, {a[31:2], 2'b00}}) begin
            n_fail++; $display("FAIL load_bus f3=%0d: got req=%b we=%b a=%h", f3, dmem_req, dmem_we, dmem_addr);
        end
        dmem_ack = 1'b1; dmem_rdata = rdw;
        step();
        dmem_ack = 1'b0;
        n_checks++;
        if ({res_valid, result, rd, rd_we} !== {1'b1, exp, 5'd9, 1'b1}) begin
            n_fail++; $display("FAIL load f3=%0d a=%h: got v=%b res=%h rd=%0d we=%b want 1 %h 9 1",
                f3, a, res_valid, result, rd, rd_we, exp);
        end
    endtask

    task automatic test_exceptions(input logic is_ld, input logic [2:0] f3, input logic [31:0] a,
                                   input logic exp_mis, input logic exp_ill);
        drive(is_ld, ~is_ld, f3, a, 32'h0, 5'd3, 1'b1);
        step();
        release_inputs();
        n_checks++;
        if ({res_valid, misaligned, illegal, rd_we, dmem_req, ready} !== {1'b1, exp_mis, exp_ill, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL exception ld=%b f3=%0d a=%h: got v=%b mis=%b ill=%b we=%b req=%b rdy=%b want mis=%b ill=%b",
                is_ld, f3, a, res_valid, misaligned, illegal, rd_we, dmem_req, ready, exp_mis, exp_ill);
        end
        step();
        n_checks++;
        if ({res_valid, dmem_req} !== 2'b00) begin
            n_fail++; $display("FAIL exception_quiet: got v=%b req=%b want 0 0", res_valid, dmem_req);
        end
    endtask

    task automatic test_timeout();
        drive(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd4, 1'b0);
        step();
        release_inputs();
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if ({res_valid, dmem_req} !== 2'b01) begin
                n_fail++; $display("FAIL timeout_wait cycle %0d: got v=%b req=%b want 0 1", i, res_valid, dmem_req);
            end
            step();
        end
        n_checks++;
        if ({res_valid, dmem_req} !== 2'b01) begin
            n_fail++; $display("FAIL timeout_last: got v=%b req=%b want 0 1", res_valid, dmem_req);
        end
        step();
        n_checks++;
        if ({res_valid, bus_err, rd_we, dmem_req, ready} !== 5'b11001) begin
            n_fail++; $display("FAIL timeout_err: got v=%b err=%b we=%b req=%b rdy=%b want 1 1 0 0 1",
                res_valid, bus_err, rd_we, dmem_req, ready);
        end
        step();
        n_checks++;
        if ({res_valid, bus_err} !== 2'b00) begin
            n_fail++; $display("FAIL timeout_pulse: got v=%b err=%b want 0 0", res_valid, bus_err);
        end
    endtask

    task automatic test_late_ack(input int busy_cycle);
        drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd6, 1'b0);
        step();
        release_inputs();
        for (int i = 1; i < busy_cycle; i++) step();
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        step();
        dmem_ack = 1'b0;
        n_checks++;
        if ({res_valid, bus_err, result, rd_we} !== {1'b1, 1'b0, 32'hCAFE_F00D, 1'b1}) begin
            n_fail++; $display("FAIL late_ack busy_cycle=%0d: got v=%b err=%b res=%h we=%b want 1 0 cafef00d 1",
                busy_cycle, res_valid, bus_err, result, rd_we);
        end
    endtask

    task automatic test_reset_in_busy();
        drive(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd8, 1'b0);
        step();
        release_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({dmem_req, ready, res_valid} !== 3'b010) begin
            n_fail++; $display("FAIL reset_busy: got req=%b rdy=%b v=%b want 0 1 0", dmem_req, ready, res_valid);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        step();
        dmem_ack = 1'b0;
        n_checks++;
        if ({dmem_req, ready, res_valid} !== 3'b010) begin
            n_fail++; $display("FAIL reset_busy_ack: got req=%b rdy=%b v=%b want 0 1 0", dmem_req, ready, res_valid);
        end
    endtask

    task automatic test_flush();
        drive(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd2, 1'b1);
        flush = 1'b1;
        step();
        release_inputs();
        n_checks++;
        if ({res_valid, ready, dmem_req} !== 3'b010) begin
            n_fail++; $display("FAIL flush_idle: got v=%b rdy=%b req=%b want 0 1 0", res_valid, ready, dmem_req);
        end
        drive(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd10, 1'b0);
        step();
        drive(1'b0, 1'b0, 3'b000, 32'h99, 32'h0, 5'd1, 1'b1);
        flush = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_BEEF;
        step();
        release_inputs();
        dmem_ack = 1'b0;
        n_checks++;
        if ({res_valid, result, rd, rd_we} !== {1'b1, 32'h0BAD_BEEF, 5'd10, 1'b1}) begin
            n_fail++; $display("FAIL flush_busy: got v=%b res=%h rd=%0d we=%b want 1 0badbeef 10 1", res_valid, result, rd, rd_we);
        end
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        n_checks++;
        if ({res_valid, dmem_req} !== 2'b00) begin
            n_fail++; $display("FAIL ack_idle: got v=%b req=%b want 0 0", res_valid, dmem_req);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 3'b000, 32'hA000 + i, 32'h0, 5'(i + 11), 1'b1);
            step();
            n_checks++;
            if ({res_valid, result, rd, ready} !== {1'b1, 32'hA000 + i, 5'(i + 11), 1'b1}) begin
                n_fail++; $display("FAIL back_to_back %0d: got v=%b res=%h rd=%0d rdy=%b", i, res_valid, result, rd, ready);
            end
        end
        drive(1'b0, 1'b1, 3'b001, 32'h601, 32'h0, 5'd0, 1'b0);
        step();
        drive(1'b0, 1'b0, 3'b000, 32'hBEEF, 32'h0, 5'd20, 1'b1);
        n_checks++;
        if ({res_valid, misaligned, rd_we} !== 3'b110) begin
            n_fail++; $display("FAIL b2b_misaligned: got v=%b mis=%b we=%b want 1 1 0", res_valid, misaligned, rd_we);
        end
        step();
        release_inputs();
        n_checks++;
        if ({res_valid, misaligned, result, rd_we} !== {1'b1, 1'b0, 32'hBEEF, 1'b1}) begin
            n_fail++; $display("FAIL b2b_after_exc: got v=%b mis=%b res=%h we=%b", res_valid, misaligned, result, rd_we);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_non_mem();
        test_store(3'b000, 32'h103, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 2);
        test_store(3'b001, 32'h102, 32'h0000_1234, 4'b1100, 32'h1234_1234, 0);
        test_store(3'b010, 32'h104, 32'h8765_4321, 4'b1111, 32'h8765_4321, 1);
        test_load(3'b000, 32'h102, 32'h0080_0000, 32'hFFFF_FF80);
        test_load(3'b100, 32'h102, 32'h0080_0000, 32'h0000_0080);
        test_load(3'b001, 32'h102, 32'h8001_0000, 32'hFFFF_8001);
        test_load(3'b101, 32'h102, 32'h8001_0000, 32'h0000_8001);
        test_load(3'b000, 32'h101, 32'h0000_7F00, 32'h0000_007F);
        test_load(3'b010, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        test_exceptions(1'b1, 3'b010, 32'h102, 1'b1, 1'b0);
        test_exceptions(1'b1, 3'b011, 32'h102, 1'b0, 1'b1);
        test_exceptions(1'b1, 3'b001, 32'h103, 1'b1, 1'b0);
        test_exceptions(1'b0, 3'b100, 32'h100, 1'b0, 1'b1);
        test_exceptions(1'b1, 3'b110, 32'h100, 1'b0, 1'b1);
        test_timeout();
        test_late_ack(4);
        test_late_ack(5);
        test_reset_in_busy();
        test_flush();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
